// File: rtl/tick_time_keeper.sv
// Tick-to-seconds prescaler with a 24-hour BCD time of day and a checked load port.
// Optional alarm comparator is enabled with `define TICK_TIME_KEEPER_ALARM_EN.
module tick_time_keeper #(
  parameter int TICKS_PER_SEC = 4,
  parameter int PS_BIT        = 16
) (
  input  logic       i_clkin,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_run,
  input  logic       i_set_valid,
  output logic       o_set_ready,
  input  logic [7:0] i_set_hh,
  input  logic [7:0] i_set_mm,
  input  logic [7:0] i_set_ss,
  output logic       o_set_err,
  output logic [7:0] o_hh,
  output logic [7:0] o_mm,
  output logic [7:0] o_ss,
  output logic       o_sec_pulse,
`ifdef TICK_TIME_KEEPER_ALARM_EN
  input  logic [7:0] i_alarm_hh,
  input  logic [7:0] i_alarm_mm,
  input  logic       i_alarm_en,
  output logic       o_alarm,
`endif
  output logic       o_day_pulse
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam logic [PS_BIT-1:0] PS_MAX = PS_BIT'(TICKS_PER_SEC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PS_BIT-1:0] r_ps;
  logic [7:0]        r_hh, r_mm, r_ss;
  logic [7:0]        r_hold_hh, r_hold_mm, r_hold_ss;
  logic              r_sec_pulse, r_day_pulse;
  logic [7:0]        w_hh_nxt, w_mm_nxt, w_ss_nxt;
  logic              w_day_wrap;
  logic              w_tick_qual, w_advance, w_accept, w_hold_ok;

  // Legal BCD time: decimal digits only, within 23:59:59.
  function automatic logic bcd_time_ok(input logic [7:0] h, input logic [7:0] m,
                                       input logic [7:0] s);
    bcd_time_ok = (h[3:0] <= 4'd9) && (m[3:0] <= 4'd9) && (s[3:0] <= 4'd9) &&
                  (h <= 8'h23) && (m <= 8'h59) && (s <= 8'h59);
  endfunction

  assign o_set_ready = (r_state == ST_RUN) & ~i_rst;
  assign w_accept    = i_set_valid & o_set_ready;
  assign w_tick_qual = i_tick & i_run & (r_state == ST_RUN);
  assign w_advance   = w_tick_qual & (r_ps == PS_MAX);
  assign w_hold_ok   = bcd_time_ok(r_hold_hh, r_hold_mm, r_hold_ss);
  assign o_set_err   = (r_state == ST_CHECK) & ~w_hold_ok & ~i_rst;

  assign o_hh        = r_hh;
  assign o_mm        = r_mm;
  assign o_ss        = r_ss;
  assign o_sec_pulse = r_sec_pulse;
  assign o_day_pulse = r_day_pulse;

  // One-second BCD cascade; every digit resolves for the same edge.
  always_comb begin
    w_ss_nxt   = r_ss;
    w_mm_nxt   = r_mm;
    w_hh_nxt   = r_hh;
    w_day_wrap = 1'b0;
    if (r_ss[3:0] != 4'd9) begin
      w_ss_nxt = {r_ss[7:4], r_ss[3:0] + 4'd1};
    end else if (r_ss[7:4] != 4'd5) begin
      w_ss_nxt = {r_ss[7:4] + 4'd1, 4'd0};
    end else begin
      w_ss_nxt = 8'h00;
      if (r_mm[3:0] != 4'd9) begin
        w_mm_nxt = {r_mm[7:4], r_mm[3:0] + 4'd1};
      end else if (r_mm[7:4] != 4'd5) begin
        w_mm_nxt = {r_mm[7:4] + 4'd1, 4'd0};
      end else begin
        w_mm_nxt = 8'h00;
        if (r_hh == 8'h23) begin
          w_hh_nxt   = 8'h00;
          w_day_wrap = 1'b1;
        end else if (r_hh[3:0] != 4'd9) begin
          w_hh_nxt = {r_hh[7:4], r_hh[3:0] + 4'd1};
        end else begin
          w_hh_nxt = {r_hh[7:4] + 4'd1, 4'd0};
        end
      end
    end
  end

  // Next-state: an accepted load spends exactly one cycle in CHECK.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_CHECK: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge i_clkin) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prescaler, time of day, load holding register and strobes.
  always_ff @(posedge i_clkin) begin
    if (i_rst) begin
      r_ps        <= '0;
      r_hh        <= 8'h00;
      r_mm        <= 8'h00;
      r_ss        <= 8'h00;
      r_hold_hh   <= 8'h00;
      r_hold_mm   <= 8'h00;
      r_hold_ss   <= 8'h00;
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
    end else begin
      r_sec_pulse <= w_advance;
      r_day_pulse <= w_advance & w_day_wrap;
      if ((r_state == ST_CHECK) && w_hold_ok) begin
        r_hh <= r_hold_hh;
        r_mm <= r_hold_mm;
        r_ss <= r_hold_ss;
        r_ps <= '0;
      end else if (w_tick_qual) begin
        if (r_ps == PS_MAX) begin
          r_ps <= '0;
          r_hh <= w_hh_nxt;
          r_mm <= w_mm_nxt;
          r_ss <= w_ss_nxt;
        end else begin
          r_ps <= r_ps + PS_BIT'(1);
        end
      end
      // Ticks that arrive during CHECK are intentionally dropped by w_tick_qual.
      if (w_accept) begin
        r_hold_hh <= i_set_hh;
        r_hold_mm <= i_set_mm;
        r_hold_ss <= i_set_ss;
      end
    end
  end

`ifdef TICK_TIME_KEEPER_ALARM_EN
  logic r_alarm;
  logic w_alarm_hit;

  assign w_alarm_hit = i_alarm_en && (w_hh_nxt == i_alarm_hh) &&
                       (w_mm_nxt == i_alarm_mm) && (w_ss_nxt == 8'h00);
  assign o_alarm     = r_alarm;

  // Alarm only fires on a counted second, never on a load.
  always_ff @(posedge i_clkin) begin
    if (i_rst) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= w_advance & w_alarm_hit;
    end
  end
`endif

endmodule

// File: tb/tb_tick_time_keeper.sv
// Directed bench for tick_time_keeper with a seconds-since-midnight reference model
// and a scoreboard of expected second strobes.
module tb_tick_time_keeper;
  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
  logic       set_err;
  logic [7:0] hh, mm, ss;
  logic       sec_pulse, day_pulse;
`ifdef TICK_TIME_KEEPER_ALARM_EN
  logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic       alarm_en = 1'b0;
  logic       alarm;
  int         n_alarm = 0;
`endif

  typedef struct {
    logic [23:0] t;
    logic        day;
  } ev_t;
  ev_t exp_q[$];

  int total = 0;
  int bad   = 0;

  int m_secs = 0;
  int m_ps = 0;
  int m_hold = 0;
  bit m_check = 1'b0;
  bit m_hold_ok = 1'b0;
  bit m_sec_exp = 1'b0;
  bit m_alarm_exp = 1'b0;

  tick_time_keeper #(.TICKS_PER_SEC(TPS), .PS_BIT(16)) dut (
    .i_clkin(clk), .i_rst(rst), .i_tick(tick), .i_run(run),
    .i_set_valid(set_valid), .o_set_ready(set_ready),
    .i_set_hh(set_hh), .i_set_mm(set_mm), .i_set_ss(set_ss),
    .o_set_err(set_err), .o_hh(hh), .o_mm(mm), .o_ss(ss),
    .o_sec_pulse(sec_pulse),
`ifdef TICK_TIME_KEEPER_ALARM_EN
    .i_alarm_hh(alarm_hh), .i_alarm_mm(alarm_mm), .i_alarm_en(alarm_en), .o_alarm(alarm),
`endif
    .o_day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [23:0] secs_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit load_ok(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    return (h[3:0] < 4'd10) && (m[3:0] < 4'd10) && (s[3:0] < 4'd10) &&
           (bcd2int(h) < 24) && (bcd2int(m) < 60) && (bcd2int(s) < 60);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check handshake outputs, advance model, check registered outputs.
  task automatic step(input logic t, input logic r, input logic sv, input logic rs);
    bit  day;
    ev_t e;
    tick = t; run = r; set_valid = sv; rst = rs;
    #1;
    chk("set_ready", set_ready, 32'(!m_check && !rs));
    chk("set_err", set_err, 32'(m_check && !m_hold_ok && !rs));
    m_sec_exp = 1'b0;
    m_alarm_exp = 1'b0;
    if (rs) begin
      m_secs = 0; m_ps = 0; m_check = 1'b0;
    end else if (m_check) begin
      if (m_hold_ok) begin
        m_secs = m_hold; m_ps = 0;
      end
      m_check = 1'b0;
    end else begin
      if (t && r) begin
        if (m_ps == TPS - 1) begin
          m_ps = 0;
          day = (m_secs == 86399);
          m_secs = (m_secs + 1) % 86400;
          m_sec_exp = 1'b1;
          exp_q.push_back('{secs_bcd(m_secs), day});
`ifdef TICK_TIME_KEEPER_ALARM_EN
          m_alarm_exp = alarm_en &&
                        (m_secs == bcd2int(alarm_hh) * 3600 + bcd2int(alarm_mm) * 60);
`endif
        end else begin
          m_ps++;
        end
      end
      if (sv) begin
        m_check = 1'b1;
        m_hold_ok = load_ok(set_hh, set_mm, set_ss);
        m_hold = bcd2int(set_hh) * 3600 + bcd2int(set_mm) * 60 + bcd2int(set_ss);
      end
    end
    @(posedge clk);
    #1;
    chk("time", {8'h00, hh, mm, ss}, {8'h00, secs_bcd(m_secs)});
    chk("sec_pulse", sec_pulse, 32'(m_sec_exp));
    if (sec_pulse === 1'b1) begin
      chk("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_time", {8'h00, hh, mm, ss}, {8'h00, e.t});
        chk("sb_day", day_pulse, 32'(e.day));
      end
    end else begin
      chk("day_idle", day_pulse, 32'd0);
    end
`ifdef TICK_TIME_KEEPER_ALARM_EN
    chk("alarm", alarm, 32'(m_alarm_exp));
    if (alarm === 1'b1) n_alarm++;
`endif
  endtask

  // Present a load value; it is scrambled after the accept step to prove it is captured.
  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hh = h; set_mm = m; set_ss = s;
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_time", {8'h00, hh, mm, ss}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("prescale_ss", ss, 32'h02);

    set_time(8'h23, 8'h59, 8'h59);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    set_time(8'hAA, 8'hBB, 8'hCC);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("load_235959", {8'h00, hh, mm, ss}, 32'h235959);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rollover", {8'h00, hh, mm, ss}, 32'h000000);

    set_time(8'h12, 8'h60, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    set_time(8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("invalid_keeps", {8'h00, hh, mm, ss}, 32'h000000);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    set_time(8'h10, 8'h20, 8'h30);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("collide_sec", {8'h00, hh, mm, ss}, 32'h000001);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("collide_load", {8'h00, hh, mm, ss}, 32'h102030);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ps_cleared", {8'h00, hh, mm, ss}, 32'h102030);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("after_load_sec", {8'h00, hh, mm, ss}, 32'h102031);

    set_time(8'h01, 8'h02, 8'h03);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    set_time(8'h04, 8'h05, 8'h06);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("back_to_back", {8'h00, hh, mm, ss}, 32'h040506);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("hold", {8'h00, hh, mm, ss}, 32'h040506);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("train", {8'h00, hh, mm, ss}, 32'h040507);

    set_time(8'h12, 8'h60, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_in_check", {8'h00, hh, mm, ss}, 32'h000000);

`ifdef TICK_TIME_KEEPER_ALARM_EN
    alarm_hh = 8'h00; alarm_mm = 8'h01; alarm_en = 1'b1;
    set_time(8'h00, 8'h00, 8'h59);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("alarm_once", n_alarm, 32'd1);
    alarm_en = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("alarm_disabled", n_alarm, 32'd1);
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
